// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the adder peripheral sequencing controller.
package adder_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned CHUNK_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_WRITE    = 2'd2,
    ST_WAIT_CLR = 2'd3
  } adder_ctrl_state_t;

  function automatic int unsigned calc_nch(input int unsigned data_w, input int unsigned chunk_w);
    return data_w / chunk_w;
  endfunction

  // Slice counter width; a single-slice add still gets a 1-bit counter.
  function automatic int unsigned calc_cnt_w(input int unsigned data_w, input int unsigned chunk_w);
    int unsigned nch;
    nch = data_w / chunk_w;
    return (nch > 32'd1) ? 32'($clog2(nch)) : 32'd1;
  endfunction

endpackage

// File: rtl/adder_ctrl_if.sv
// Register-file datapath bundle between the register file and the adder controller.
interface adder_ctrl_if
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              i_start;
  logic [DATA_W-1:0] i_r0;
  logic [DATA_W-1:0] i_r1;
  logic [DATA_W-1:0] o_busr;
  logic              o_enable_ctrl_write;
  logic              o_carry;
  logic              o_ovf;
  logic              o_busy;

  // Controller side.
  modport master (
    input  i_start, i_r0, i_r1,
    output o_busr, o_enable_ctrl_write, o_carry, o_ovf, o_busy
  );

  // Register-file side.
  modport slave (
    output i_start, i_r0, i_r1,
    input  o_busr, o_enable_ctrl_write, o_carry, o_ovf, o_busy
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational CHUNK_W-bit adder slice with carry-in and carry-out.
module adder_slice
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK_W = CHUNK_W_DEF
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_c_o,
  output logic               cout_c_o
);

  assign {cout_c_o, sum_c_o} = (CHUNK_W+1)'(a_i) + (CHUNK_W+1)'(b_i) + (CHUNK_W+1)'(cin_i);

endmodule

// File: rtl/adder_ctrl.sv
// Adder sequencing controller: latches operands on start, adds them slice by slice
// with a registered carry, writes the sum back with a one-cycle strobe, re-arms on start low.
module adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CHUNK_W = CHUNK_W_DEF
) (
  input  logic         ACLK,
  input  logic         ARST,
  adder_ctrl_if.master bus
);

  localparam int unsigned      NCH      = calc_nch(DATA_W, CHUNK_W);
  localparam int unsigned      CNT_W    = calc_cnt_w(DATA_W, CHUNK_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  typedef logic [CHUNK_W-1:0] chunk_t;

  adder_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  chunk_t            a_q [NCH];
  chunk_t            a_d [NCH];
  chunk_t            b_q [NCH];
  chunk_t            b_d [NCH];
  chunk_t            sum_q [NCH];
  chunk_t            sum_d [NCH];
  chunk_t            r0_sl [NCH];
  chunk_t            r1_sl [NCH];
  logic [DATA_W-1:0] sum_full_c;

  logic [DATA_W-1:0] busr_q, busr_d;
  logic              wr_q, wr_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  chunk_t            a_cur_c, b_cur_c, slice_sum_c;
  logic              slice_cout_c;

  // Slice views of the operand inputs and the assembled next-state sum.
  for (genvar g = 0; g < NCH; g++) begin : g_slices
    assign r0_sl[g]                         = bus.i_r0[g*CHUNK_W +: CHUNK_W];
    assign r1_sl[g]                         = bus.i_r1[g*CHUNK_W +: CHUNK_W];
    assign sum_full_c[g*CHUNK_W +: CHUNK_W] = sum_d[g];
  end

  assign a_cur_c = a_q[cnt_q];
  assign b_cur_c = b_q[cnt_q];

  adder_slice #(.CHUNK_W(CHUNK_W)) u_slice (
    .a_i      (a_cur_c),
    .b_i      (b_cur_c),
    .cin_i    (carry_q),
    .sum_c_o  (slice_sum_c),
    .cout_c_o (slice_cout_c)
  );

  always_comb begin
    sum_d = sum_q;
    if (state_q == ST_EXEC) begin
      sum_d[cnt_q] = slice_sum_c;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    busr_d  = busr_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          a_d     = r0_sl;
          b_d     = r1_sl;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        carry_d = slice_cout_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Top slice is in flight, so its sum MSB is the result's sign bit.
          cnt_d   = '0;
          busr_d  = sum_full_c;
          cout_d  = slice_cout_c;
          ovf_d   = (a_cur_c[CHUNK_W-1] == b_cur_c[CHUNK_W-1]) &&
                    (slice_sum_c[CHUNK_W-1] != a_cur_c[CHUNK_W-1]);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!bus.i_start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_d   = (state_d == ST_WRITE);
    busy_d = (state_d == ST_EXEC) || (state_d == ST_WRITE);
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sum_q   <= '{default: '0};
      busr_q  <= '0;
      wr_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      busr_q  <= busr_d;
      wr_q    <= wr_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_busr              = busr_q;
  assign bus.o_enable_ctrl_write = wr_q;
  assign bus.o_carry             = cout_q;
  assign bus.o_ovf               = ovf_q;
  assign bus.o_busy              = busy_q;

endmodule

// File: tb/tb_adder_ctrl.sv
// Bench for adder_ctrl: directed operations checked against literals and a cycle-level
// model that applies the add with plain wide arithmetic.
module tb_adder_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 8;
  localparam int          NCH = DW / CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   strobes  = 0;

  adder_ctrl_if #(.DATA_W(DW)) bus ();

  adder_ctrl #(.DATA_W(DW), .CHUNK_W(CW)) dut (
    .ACLK (clk),
    .ARST (rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Model: m_cnt counts edges since the start was sampled (-1 when no operation).
  int          m_cnt  = -1;
  logic        m_wait = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_sum = '0;
  logic        m_c = 1'b0, m_v = 1'b0;
  logic [DW:0] m_res;
  logic        m_ovf;

  assign m_res = {1'b0, m_a} + {1'b0, m_b};
  assign m_ovf = (m_a[DW-1] == m_b[DW-1]) && (m_res[DW-1] != m_a[DW-1]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= -1;
      m_wait <= 1'b0;
      m_sum  <= '0;
      m_c    <= 1'b0;
      m_v    <= 1'b0;
    end else if (m_cnt >= 0) begin
      if (m_cnt == NCH - 1) begin
        m_sum <= m_res[DW-1:0];
        m_c   <= m_res[DW];
        m_v   <= m_ovf;
      end
      if (m_cnt == NCH) begin
        m_cnt  <= -1;
        m_wait <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (m_wait) begin
      if (!bus.i_start) m_wait <= 1'b0;
    end else if (bus.i_start) begin
      m_a   <= bus.i_r0;
      m_b   <= bus.i_r1;
      m_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model_busr",  64'(bus.o_busr), 64'(m_sum));
      check("model_carry", 64'(bus.o_carry), 64'(m_c));
      check("model_ovf",   64'(bus.o_ovf), 64'(m_v));
      check("model_wr",    64'(bus.o_enable_ctrl_write), 64'(m_cnt == NCH));
      check("model_busy",  64'(bus.o_busy), 64'(m_cnt >= 0));
      if (bus.o_enable_ctrl_write) strobes++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Counts sampling points from the first one after the start edge until the strobe.
  task automatic wait_strobe(output int n, output int busy_n);
    n = 1;
    busy_n = 0;
    while (!bus.o_enable_ctrl_write && n < 30) begin
      if (bus.o_busy) busy_n++;
      step();
      n++;
    end
    if (bus.o_busy) busy_n++;
  endtask

  task automatic run_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] es, input logic ec, input logic ev);
    int n, busy_n;
    bus.i_r0    = a;
    bus.i_r1    = b;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_r0    = ~a;
    bus.i_r1    = ~b;
    wait_strobe(n, busy_n);
    check({name, "_latency"}, 64'(n), 64'(NCH + 1));
    check({name, "_sum"},     64'(bus.o_busr), 64'(es));
    check({name, "_carry"},   64'(bus.o_carry), 64'(ec));
    check({name, "_ovf"},     64'(bus.o_ovf), 64'(ev));
    step();
    if (bus.o_busy) busy_n++;
    step();
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(NCH + 1));
  endtask

  initial begin
    int base, n, busy_n;
    bus.i_start = 1'b0;
    bus.i_r0    = '0;
    bus.i_r1    = '0;

    step();
    step();
    check("rst_busr",  64'(bus.o_busr), 64'd0);
    check("rst_wr",    64'(bus.o_enable_ctrl_write), 64'd0);
    check("rst_carry", 64'(bus.o_carry), 64'd0);
    check("rst_ovf",   64'(bus.o_ovf), 64'd0);
    check("rst_busy",  64'(bus.o_busy), 64'd0);
    rst = 1'b0;

    repeat (10) step();
    check("idle_no_strobe", 64'(strobes), 64'd0);

    run_op("basic",   32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
    run_op("carries", 32'h00FF_00FF, 32'h0001_FF01, 32'h0101_0000, 1'b0, 1'b0);
    run_op("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    run_op("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    run_op("negovf",  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

    // Reset lands mid-operation, one time unit after the third edge.
    base        = strobes;
    bus.i_r0    = 32'h1111_1111;
    bus.i_r1    = 32'h2222_2222;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.o_busy), 64'd0);
    check("midrst_wr",   64'(bus.o_enable_ctrl_write), 64'd0);
    check("midrst_busr", 64'(bus.o_busr), 64'd0);
    step();
    step();
    rst = 1'b0;
    repeat (8) step();
    check("midrst_no_strobe", 64'(strobes - base), 64'd0);
    run_op("after_rst", 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0);

    // Start held high: one operation only, operand changes after the start are ignored.
    base        = strobes;
    bus.i_r0    = 32'd10;
    bus.i_r1    = 32'd20;
    bus.i_start = 1'b1;
    step();
    bus.i_r0    = 32'hDEAD_BEEF;
    repeat (19) step();
    check("hold_one_strobe", 64'(strobes - base), 64'd1);
    check("hold_sum",        64'(bus.o_busr), 64'd30);
    check("hold_busy",       64'(bus.o_busy), 64'd0);

    bus.i_start = 1'b0;
    step();
    bus.i_r0    = 32'h0000_0100;
    bus.i_r1    = 32'h0000_0023;
    bus.i_start = 1'b1;
    step();
    bus.i_r0    = 32'hFFFF_0000;
    bus.i_r1    = 32'h0F0F_0F0F;
    wait_strobe(n, busy_n);
    check("rearm_latency", 64'(n), 64'(NCH + 1));
    check("rearm_sum",     64'(bus.o_busr), 64'h0000_0123);
    check("rearm_strobes", 64'(strobes - base), 64'd2);
    bus.i_start = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_ctrl.md
# adder_ctrl

Sequencing controller for the AMBA adder peripheral's datapath. Waits for the start flag from the register file, latches both operands, and adds them in `CHUNK_W`-bit slices over several cycles with a registered carry. It writes the sum back to the register file through the control-write path with a one-cycle strobe, then re-arms only after the start flag has been cleared. It sits between the register file's datapath ports and the AMBA slave logic.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width.
- `CHUNK_W`, 8: bits added per cycle. Must divide `DATA_W`. `CHUNK_W == DATA_W` gives a single-slice add.

Ports:
- `ACLK`  in  1: clock; all state changes on the rising edge.
- `ARST`  in  1: reset, asynchronous, active-high.
- `i_start`  in  1: start flag from the register file (level).
- `i_r0`  in  DATA_W: operand A.
- `i_r1`  in  DATA_W: operand B.
- `o_busr`  out  DATA_W: result bus to the register file.
- `o_enable_ctrl_write`  out  1: one-cycle write strobe. The register file stores `o_busr` and clears the start flag on it.
- `o_carry`  out  1: unsigned carry-out of the last add.
- `o_ovf`  out  1: signed overflow of the last add.
- `o_busy`  out  1: high while an operation is in flight.

## Operation
- States: IDLE, EXEC, WRITE, WAIT_CLR. All are registered; outputs are Moore.
- **IDLE**
  - If `i_start`=1 at an edge: latch `i_r0` and `i_r1` into operand registers, clear the carry register, set slice counter to 0, go to EXEC.
- **EXEC**
  - Each edge computes one slice: `sum[k*CHUNK_W +: CHUNK_W] = a_slice + b_slice + carry`, then updates carry and increments the counter.
  - After slice NCH-1 (NCH = DATA_W/CHUNK_W), go to WRITE.
  - On the last-slice edge:
    - `o_carry` takes the final carry.
    - `o_ovf` takes (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- **WRITE**
  - `o_enable_ctrl_write`=1 for exactly this cycle; `o_busr` = full sum. Next edge goes to WAIT_CLR.
- **WAIT_CLR**
  - Stay while `i_start`=1; go to IDLE on the first edge with `i_start`=0.
  - A start held high therefore never triggers a second operation.
- `o_busy` = 1 in EXEC and WRITE, 0 otherwise.
- `o_busr`, `o_carry` and `o_ovf` hold their last values until the next WRITE.
- Arithmetic is modulo 2^DATA_W; the carry is not added into the result.

## Timing
- Reset values: state IDLE, `o_busr`=0, `o_enable_ctrl_write`=0, `o_carry`=0, `o_ovf`=0, `o_busy`=0, counter 0.
- Let E0 be the edge where IDLE samples `i_start`=1.
  - Edges E1..E_NCH process slices 0..NCH-1.
  - The strobe is high in the cycle after E_NCH, i.e. after NCH+1 edges counting E0. With defaults, the strobe is high between E4 and E5.
- Operand changes after E0 are ignored.
- `i_start` dropping during EXEC or WRITE is ignored; the operation completes and writes back.
- `ARST` asserted mid-operation:
  - Immediate (asynchronous) return to reset values.
  - No strobe is issued and the partial sum is discarded.
- `i_start` already high when `ARST` releases: the operation begins at the first edge after release.
- Minimum spacing between operations: NCH+3 cycles (WAIT_CLR consumes at least one cycle with `i_start` low).

## Structure
- Package `adder_pkg`:
  - state enum `adder_ctrl_state_t` (IDLE, EXEC, WRITE, WAIT_CLR);
  - `DATA_W` default constant;
  - a constant function for NCH and counter width ($clog2(NCH), minimum 1).
- Sub-module `adder_slice`:
  - combinational `CHUNK_W`-bit adder, carry-in to {carry-out, sum};
  - instantiated once and indexed by the slice counter.

## Test plan
- **Reset:** assert `ARST` for 2 cycles → all outputs 0, `o_busy`=0. Hold `i_start`=0 for 10 cycles → no strobe.
- **Basic add:** `i_r0`=0x0000_0005, `i_r1`=0x0000_0003, pulse `i_start` → strobe in the cycle after E4, `o_busr`=0x0000_0008, `o_carry`=0, `o_ovf`=0, `o_busy` high for exactly 5 cycles.
- **Carry across slices:** 0x00FF_00FF + 0x0001_FF01 → `o_busr`=0x0101_0000, `o_carry`=0.
- **Carry-out and overflow:**
  - 0xFFFF_FFFF + 0x0000_0001 → `o_busr`=0, `o_carry`=1, `o_ovf`=0.
  - 0x7FFF_FFFF + 0x0000_0001 → 0x8000_0000, `o_carry`=0, `o_ovf`=1.
- **Reset mid-operation:** assert `ARST` at E2 + 1ns of an operation → `o_busy` drops with no clock edge needed, no strobe appears. A fresh start with 2 + 2 then yields 0x4.
- **Re-arm rule:** hold `i_start`=1 for 20 cycles → exactly one strobe. Drop `i_start` for 1 cycle, then raise it → second strobe NCH+1 edges after the new sample. Operands changed after E0 do not affect the result.
